// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage float32 -> int32 converter, round half away from zero.
// Build option FTOI_SAT_EN: saturate out-of-range results instead of 0x80000000.
module ftoi_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic        s1_valid_q;
  logic        s1_sign_q;
  logic        s1_ovf_q;
  logic [32:0] s1_a_q;
  logic        y_valid_q;
  logic [31:0] y_q;
  logic        ovf_q;

  logic        s2_load;
  logic [7:0]  e;
  logic [23:0] mant;
  logic [31:0] shr;
  logic [32:0] a_d;
  logic        ovf_d;
  logic [31:0] mag;
  logic [31:0] y_d;

`ifdef FTOI_SAT_EN
  logic        s1_nan_q;
  logic        nan_d;
  assign nan_d = (e == 8'd255) && (x[22:0] != 23'd0);
`endif

  assign s2_load = !y_valid_q || y_ready;
  assign x_ready = !s1_valid_q || s2_load;
  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign ovf     = ovf_q;

  assign e    = x[30:23];
  assign mant = {1'b1, x[22:0]};

  // Stage 1: align the mantissa into {integer magnitude, round bit}.
  always_comb begin
    a_d   = '0;
    ovf_d = 1'b0;
    shr   = '0;
    if (e <= 8'd125) begin
      a_d = '0;
    end else if (e <= 8'd149) begin
      // Shift one less than needed so the round bit lands in bit 0.
      shr = {8'b0, mant} >> (8'd149 - e);
      a_d = {1'b0, shr};
    end else if (e <= 8'd157) begin
      a_d = {{8'b0, mant} << (e - 8'd150), 1'b0};
    end else begin
      // -2^31 is the only representable value with e >= 158.
      ovf_d = !(x[31] && (e == 8'd158) && (x[22:0] == 23'd0));
      a_d   = {32'h8000_0000, 1'b0};
    end
  end

  // Stage 2: round, apply sign, substitute the overflow value.
  always_comb begin
    mag = s1_a_q[32:1] + {31'b0, s1_a_q[0]};
    y_d = s1_sign_q ? (~mag + 32'd1) : mag;
    if (s1_ovf_q) begin
`ifdef FTOI_SAT_EN
      if (s1_nan_q || !s1_sign_q) y_d = 32'h7FFF_FFFF;
      else                        y_d = 32'h8000_0000;
`else
      y_d = 32'h8000_0000;
`endif
    end
  end

  // Stage 1 register: loads whenever the stage can accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_a_q     <= '0;
    end else if (x_ready) begin
      s1_valid_q <= x_valid;
      s1_sign_q  <= x[31];
      s1_ovf_q   <= ovf_d;
      s1_a_q     <= a_d;
    end
  end

`ifdef FTOI_SAT_EN
  // NaN flag travels alongside stage 1 for saturation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        s1_nan_q <= 1'b0;
    else if (x_ready) s1_nan_q <= nan_d;
  end
`endif

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
    end else if (s2_load) begin
      y_valid_q <= s1_valid_q;
      y_q       <= y_d;
      ovf_q     <= s1_valid_q && s1_ovf_q;
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: directed vectors plus throughput, backpressure and reset
// sequences for ftoi_pipe.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [31:0] x = '0;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [31:0] y;
  logic        ovf;

  ftoi_pipe dut (
    .clk     (clk),
    .rstn    (rstn),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x       (x),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

`ifdef FTOI_SAT_EN
  localparam logic [31:0] OV_POS = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OV_POS = 32'h8000_0000;
`endif
  localparam logic [31:0] OV_NEG = 32'h8000_0000;
  localparam logic [31:0] OV_NAN = OV_POS;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  logic [31:0] tp[8];
  logic [31:0] ops[6];
  logic [31:0] opx[6];
  int idx;
  int got;

  initial begin
    tv[0]  = '{32'h3FC0_0000, 32'h0000_0002, 1'b0};
    tv[1]  = '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0};
    tv[2]  = '{32'h3F00_0000, 32'h0000_0001, 1'b0};
    tv[3]  = '{32'h3EFF_FFFF, 32'h0000_0000, 1'b0};
    tv[4]  = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0};
    tv[5]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
    tv[6]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0};
    tv[7]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};
    tv[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    tv[9]  = '{32'h4F00_0000, OV_POS,        1'b1};
    tv[10] = '{32'h7F80_0000, OV_POS,        1'b1};
    tv[11] = '{32'h7FC0_0000, OV_NAN,        1'b1};
    tv[12] = '{32'hFF80_0000, OV_NEG,        1'b1};
    tv[13] = '{32'hFFC0_0000, OV_NAN,        1'b1};
    tv[14] = '{32'hCF00_0001, OV_NEG,        1'b1};
    tv[15] = '{32'h4049_0FDB, 32'h0000_0003, 1'b0};
    tv[16] = '{32'h3FE0_0000, 32'h0000_0002, 1'b0};
    tv[17] = '{32'h4020_0000, 32'h0000_0003, 1'b0};
    tv[18] = '{32'hC020_0000, 32'hFFFF_FFFD, 1'b0};
    tv[19] = '{32'h42F6_E979, 32'h0000_007B, 1'b0};
    tv[20] = '{32'h007F_FFFF, 32'h0000_0000, 1'b0};

    tp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
           32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    opx = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
            32'h4140_0000, 32'hC150_0000, 32'h4160_0000};
    ops = '{32'd9, 32'd10, 32'd11, 32'd12, 32'hFFFF_FFF3, 32'd14};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_y_valid", {31'b0, y_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_x_ready", {31'b0, x_ready}, 32'd1);

    // Directed vectors, one at a time
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      x = tv[i].x;
      x_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_x_ready", i), {31'b0, x_ready}, 32'd1);
      @(negedge clk);
      x_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), {31'b0, y_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'b0, y_valid}, 32'd1);
      chk($sformatf("vec%0d_y", i), y, tv[i].y);
      chk($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, tv[i].ovf});
    end
    repeat (2) @(negedge clk);

    // Throughput: 8 back-to-back operands
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tp%0d_valid", c), {31'b0, y_valid},
          (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (y_valid) chk($sformatf("tp%0d_y", c), y, 32'(c - 1));
      x_valid = (c < 8);
      x = tp[(c < 8) ? c : 0];
      #1;
      if (c < 8) chk($sformatf("tp%0d_x_ready", c), {31'b0, x_ready}, 32'd1);
    end
    x_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure then release
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        chk($sformatf("bp%0d_hold_valid", c), {31'b0, y_valid}, 32'd1);
        chk($sformatf("bp%0d_hold_y", c), y, 32'd9);
      end
      if (c == 4) begin
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_x_ready", {31'b0, x_ready}, 32'd0);
      end
      y_ready = (c >= 5);
      if (y_valid && y_ready) begin
        chk($sformatf("bp_out%0d", got), y, ops[got]);
        got++;
      end
      x_valid = (idx < 6);
      x = opx[(idx < 6) ? idx : 0];
      #1;
      if (x_valid && x_ready) idx++;
    end
    chk("bp_count", 32'(got), 32'd6);
    x_valid = 1'b0;
    y_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_no_dup", {31'b0, y_valid}, 32'd0);

    // Reset with two operands in flight
    @(negedge clk);
    x = 32'h3F80_0000;
    x_valid = 1'b1;
    @(negedge clk);
    x = 32'h4000_0000;
    @(negedge clk);
    x_valid = 1'b0;
    chk("rf_pre_valid", {31'b0, y_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rf_y_valid", {31'b0, y_valid}, 32'd0);
    chk("rf_y", y, 32'd0);
    chk("rf_ovf", {31'b0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rf_x_ready", {31'b0, x_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rf_stale%0d", c), {31'b0, y_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Two-stage pipelined IEEE-754 single-precision float to 32-bit signed integer converter.
- Inverse of the FPU int-to-float path; rounding is round-to-nearest with ties away from zero, matching that path's magnitude rounding.
- Sits in the FPU execute cluster behind a valid/ready handshake, so the core can stall it.
- Sustains one conversion per cycle.

Parameters:
- None. Widths are fixed at 32-bit in and 32-bit out.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- x_valid  in  1  input operand valid.
- x_ready  out  1  block can accept an operand this cycle.
- x  in  32  float operand {s, e[7:0], m[22:0]}.
- y_valid  out  1  result valid.
- y_ready  in  1  consumer accepts the result this cycle.
- y  out  32  signed integer result.
- ovf  out  1  out-of-range flag, qualified by y_valid.

Behaviour:
- Reset (rstn low, asynchronous): s1_valid=0, y_valid=0, y=0, ovf=0, x_ready=1 once rstn is released.
- Reset mid-operation drops all in-flight operands. No result is emitted for them.
- Handshake and flow:
  - Input transfer happens when x_valid && x_ready. Output transfer happens when y_valid && y_ready.
  - s2_load = !y_valid || y_ready.
  - x_ready = !s1_valid || s2_load (combinational, no path from x_valid).
  - Stage 1 captures x when x_ready is high. s1_valid is set to x_valid on every cycle that x_ready is high.
  - Stage 2 (the output register) loads s1 contents when s2_load is high. y_valid is set to s1_valid on those cycles.
  - While y_valid && !y_ready: y and ovf hold stable and x_ready=0 if s1_valid.
  - Latency is exactly 2 cycles from input transfer to y_valid when there is no backpressure. Throughput is 1/cycle.
- Stage 1 (decode/align). Let mant={1,m} (24b). Register s, ovf_raw, and a 33-bit aligned value a = {mag_int[31:0], round_bit}:
  - e <= 125 (includes zero and denormals): a=0. The result is 0, also for negative inputs (no -0).
  - 126 <= e <= 149: sh=150-e (1..24); a = {mant >> sh, mant[sh-1]}.
  - 150 <= e <= 157: a = {mant << (e-150), 1'b0}.
  - e >= 158: ovf_raw=1, except s=1, e=158, m=0 (exactly -2^31), which is in range.
- Stage 2 (round/negate):
  - mag = a[32:1] + a[0], 32-bit unsigned. Rounding never carries past bit 31 for e<=157.
  - y = s ? (~mag + 1) : mag.
  - For in-range -2^31: y = 0x80000000, ovf=0.
  - Out-of-range: ovf=1, and y is set by the optional feature.
- NaN and Inf (e=255) follow the e >= 158 overflow rule; the sign bit is honoured.

Optional Feature:
- Macro: FTOI_SAT_EN.
- Defined: on overflow, y saturates to 0x7FFFFFFF when s=0 and to 0x80000000 when s=1. NaN of either sign gives 0x7FFFFFFF. ovf=1.
- Undefined: every overflow (including NaN and Inf) gives y=0x80000000 (integer-indefinite). ovf=1.
- Both builds drive the ovf port and share identical handshake and latency.

Test Plan:
- Basic rounding, y_ready=1: x=0x3FC00000 (1.5) -> y=0x00000002 at cycle+2, ovf=0. x=0xBFC00000 (-1.5) -> y=0xFFFFFFFE. x=0x3F000000 (0.5) -> 0x00000001. x=0x3EFFFFFF -> 0x00000000.
- Range edges: x=0x4B7FFFFF -> 0x00FFFFFF. x=0x4EFFFFFF -> 0x7FFFFF80, ovf=0. x=0xCF000000 -> 0x80000000, ovf=0. x=0x00000001 and x=0x80000000 -> 0x00000000.
- Overflow: x=0x4F000000 and x=0x7F800000 -> ovf=1, y=0x7FFFFFFF with FTOI_SAT_EN, 0x80000000 without. x=0x7FC00000 (NaN) -> ovf=1, y=0x7FFFFFFF (SAT) or 0x80000000.
- Throughput: 8 back-to-back operands with y_ready=1 -> 8 consecutive y_valid cycles, in order, first result 2 cycles after the first transfer.
- Backpressure: y_ready=0 for 5 cycles with x_valid held -> at most 2 operands accepted, x_ready=0 after that, y stable. Release y_ready -> results emerge in order with no loss or duplication.
- Reset mid-flight: assert rstn=0 asynchronously (between clock edges) with 2 operands in flight -> y_valid=0 and y=0 immediately. After rstn rises, x_ready=1 and no stale results appear.
